dmem_arbiter: RTL and testbench

- Shares the single-port 8-bit data memory between two requesters: the CPU load/store path (port 0) and a DMA/loader port (port 1).
- Each requester uses a req/ack handshake. The arbiter runs a 3-state FSM and drives the data memory address, write data, write enable and read strobe from registered values.
- Arbitration is round-robin. The DMA port can lock the grant for a bounded burst.
- Provides a stall signal so the CPU pipeline holds PC while its access is pending.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// The arbiter connects through the slave modport; requesters and memory use master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_lock;
    logic              dma_ack;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_ack,
        output rdata, mem_addr, mem_wdata, mem_we, mem_re, busy,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_ack,
        input  rdata, mem_addr, mem_wdata, mem_we, mem_re, busy,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU and a DMA port.
// Each transfer runs IDLE -> ACCESS -> DONE; DMA may hold the grant for a bounded locked burst.
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input logic             clk,
    input logic             rst,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {P_CPU, P_DMA} port_t;

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    state_t            state_q, state_d;
    port_t             owner_q, owner_d;
    port_t             last_q, last_d;
    port_t             win;
    logic [3:0]        burst_q, burst_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= P_CPU;
            last_q  <= P_DMA;
            burst_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        win     = P_CPU;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    if (!bus.dma_req)
                        win = P_CPU;
                    else if (!bus.cpu_req)
                        win = P_DMA;
                    else if (owner_q == P_DMA && bus.dma_lock && burst_q < MAXB)
                        win = P_DMA;
                    else
                        win = (last_q == P_CPU) ? P_DMA : P_CPU;
                    owner_d = win;
                    state_d = ACCESS;
                    if (win == P_DMA) begin
                        we_d    = bus.dma_we;
                        addr_d  = bus.dma_addr;
                        wdata_d = bus.dma_wdata;
                        // Locked grants count up and stick at the limit; unlocked ones restart.
                        if (bus.dma_lock)
                            burst_d = (burst_q == MAXB) ? burst_q : burst_q + 4'd1;
                        else
                            burst_d = '0;
                    end else begin
                        we_d    = bus.cpu_we;
                        addr_d  = bus.cpu_addr;
                        wdata_d = bus.cpu_wdata;
                        burst_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (!we_q)
                    rdata_d = bus.mem_rdata;
                last_d  = owner_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_we    = (state_q == ACCESS) &&  we_q;
        bus.mem_re    = (state_q == ACCESS) && !we_q;
        bus.cpu_ack   = (state_q == DONE) && (owner_q == P_CPU);
        bus.dma_ack   = (state_q == DONE) && (owner_q == P_DMA);
        bus.busy      = (state_q != IDLE);
        bus.rdata     = rdata_q;
        bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences and
// randomized traffic checked cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [7:0] tbmem [256];
    logic [7:0] refmem[256];
    assign bus.mem_rdata = tbmem[bus.mem_addr];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       lock;
        int         gap;
    } txn_t;

    typedef struct {
        bit         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // requester drivers: 0 idle, 1 waiting gap, 2 requesting
    txn_t cq[$], dq[$];
    txn_t c_cur, d_cur;
    int   c_state = 0, d_state = 0, c_wait = 0, d_wait = 0;
    bit   drop_cpu = 0;
    bit   glog[$];

    // reference model: transfer countdown (0 = free) plus arbitration history
    int         m_cd;
    bit         m_owner, m_last;
    int         m_streak;
    txn_t       m_tx;
    logic [7:0] m_rdata;
    bit e_cpu_ack, e_dma_ack, e_we, e_re, e_busy;

    function automatic txn_t mk(logic we, logic [7:0] a, logic [7:0] d, logic l, int g);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.lock = l; t.gap = g;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cd = 0; m_owner = 0; m_last = 1; m_streak = 0; m_rdata = 8'h00;
    endtask

    task automatic model_edge();
        bit w;
        e_cpu_ack = 0; e_dma_ack = 0; e_we = 0; e_re = 0; e_busy = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_cd == 0) begin
            if (bus.cpu_req || bus.dma_req) begin
                if (bus.cpu_req && !bus.dma_req)      w = 0;
                else if (bus.dma_req && !bus.cpu_req) w = 1;
                else if (m_owner && bus.dma_lock && m_streak < MB) w = 1;
                else w = !m_last;
                if (w && bus.dma_lock) m_streak = (m_streak + 1 > MB) ? MB : m_streak + 1;
                else m_streak = 0;
                m_owner    = w;
                m_tx.we    = w ? bus.dma_we    : bus.cpu_we;
                m_tx.addr  = w ? bus.dma_addr  : bus.cpu_addr;
                m_tx.wdata = w ? bus.dma_wdata : bus.cpu_wdata;
                m_cd = 2;
                e_we = m_tx.we; e_re = !m_tx.we; e_busy = 1;
            end
        end else if (m_cd == 2) begin
            if (m_tx.we) refmem[m_tx.addr] = m_tx.wdata;
            else         m_rdata = refmem[m_tx.addr];
            m_last = m_owner;
            m_cd = 1;
            e_busy = 1;
            e_cpu_ack = !m_owner;
            e_dma_ack = m_owner;
        end else begin
            m_cd = 0;
        end
    endtask

    task automatic drive();
        if (bus.cpu_ack) c_state = 0;
        if (bus.dma_ack) d_state = 0;
        if (drop_cpu && m_cd == 2 && !m_owner) begin
            c_state = 0;
            drop_cpu = 0;
        end
        if (c_state == 0 && cq.size() > 0) begin
            c_cur = cq.pop_front(); c_wait = c_cur.gap; c_state = 1;
        end
        if (c_state == 1) begin
            if (c_wait == 0) c_state = 2; else c_wait--;
        end
        if (d_state == 0 && dq.size() > 0) begin
            d_cur = dq.pop_front(); d_wait = d_cur.gap; d_state = 1;
        end
        if (d_state == 1) begin
            if (d_wait == 0) d_state = 2; else d_wait--;
        end
        bus.cpu_req   = (c_state == 2);
        bus.cpu_we    = c_cur.we;
        bus.cpu_addr  = c_cur.addr;
        bus.cpu_wdata = c_cur.wdata;
        bus.dma_req   = (d_state == 2);
        bus.dma_we    = d_cur.we;
        bus.dma_addr  = d_cur.addr;
        bus.dma_wdata = d_cur.wdata;
        bus.dma_lock  = (d_state == 2) && d_cur.lock;
    endtask

    task automatic cycle();
        logic       pw;
        logic [7:0] pa, pd;
        @(negedge clk);
        pw = bus.mem_we; pa = bus.mem_addr; pd = bus.mem_wdata;
        @(posedge clk);
        if (pw) tbmem[pa] = pd;
        #1;
        model_edge();
        chk("cpu_ack", bus.cpu_ack, e_cpu_ack);
        chk("dma_ack", bus.dma_ack, e_dma_ack);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_re", bus.mem_re, e_re);
        chk("busy", bus.busy, e_busy);
        chk("rdata", bus.rdata, m_rdata);
        chk("ack_excl", bus.cpu_ack && bus.dma_ack, 0);
        if (e_we || e_re) chk("mem_addr", bus.mem_addr, m_tx.addr);
        if (e_we) chk("mem_wdata", bus.mem_wdata, m_tx.wdata);
        if (bus.cpu_ack) glog.push_back(0);
        if (bus.dma_ack) glog.push_back(1);
        drive();
        #1;
        chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !e_cpu_ack);
    endtask

    function automatic bit all_done();
        return cq.size() == 0 && dq.size() == 0 && c_state == 0 && d_state == 0 && m_cd == 0;
    endfunction

    task automatic run_idle(input string nm, input int lim);
        int n = 0;
        while (!all_done() && n < lim) begin
            cycle();
            n++;
        end
        total++;
        if (!all_done()) begin
            bad++;
            $display("FAIL %s: timeout after %0d cycles, got busy want idle", nm, lim);
        end
    endtask

    task automatic check_log(input string nm, input string exp);
        chk({nm, "_len"}, glog.size(), exp.len());
        for (int i = 0; i < exp.len() && i < glog.size(); i++)
            chk(nm, glog[i], exp[i] == "D");
    endtask

    task automatic reset_drivers();
        cq.delete(); dq.delete();
        c_state = 0; d_state = 0;
        bus.cpu_req = 0; bus.dma_req = 0; bus.dma_lock = 0;
    endtask

    vec_t tbl[8];

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbmem[i]  = 8'($urandom);
            refmem[i] = tbmem[i];
        end
        c_cur = mk(0, 0, 0, 0, 0);
        d_cur = c_cur;
        bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        reset_drivers();
        model_reset();

        #2;
        chk("rst_cpu_ack", bus.cpu_ack, 0);
        chk("rst_dma_ack", bus.dma_ack, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_re", bus.mem_re, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);

        // both ports requesting out of reset: CPU wins the first tie
        cq.push_back(mk(0, 8'h01, 0, 0, 0)); cq.push_back(mk(0, 8'h02, 0, 0, 0));
        dq.push_back(mk(0, 8'h03, 0, 0, 0)); dq.push_back(mk(0, 8'h04, 0, 0, 0));
        cycle(); cycle();
        #1 rst = 1;
        run_idle("rr_from_reset", 60);
        check_log("rr_from_reset", "CDCD");

        tbl[0] = '{0, 1, 8'h10, 8'hA5, 8'h00};
        tbl[1] = '{0, 0, 8'h10, 8'h00, 8'hA5};
        tbl[2] = '{1, 1, 8'h11, 8'h3C, 8'h00};
        tbl[3] = '{1, 0, 8'h11, 8'h00, 8'h3C};
        tbl[4] = '{0, 0, 8'h11, 8'h00, 8'h3C};
        tbl[5] = '{1, 0, 8'h10, 8'h00, 8'hA5};
        tbl[6] = '{0, 1, 8'h00, 8'hFF, 8'h00};
        tbl[7] = '{1, 0, 8'h00, 8'h00, 8'hFF};
        for (int i = 0; i < 8; i++) begin
            glog.delete();
            if (tbl[i].port) dq.push_back(mk(tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, 0));
            else             cq.push_back(mk(tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, 0));
            run_idle("tbl_run", 20);
            check_log("tbl_port", tbl[i].port ? "D" : "C");
            if (!tbl[i].we) chk("tbl_rdata", bus.rdata, tbl[i].exp);
        end

        // locked DMA burst with the CPU waiting
        glog.delete();
        for (int i = 0; i < 6; i++) dq.push_back(mk(1, 8'(8'h20 + i), 8'(i + 1), 1, 0));
        cycle(); cycle();
        cq.push_back(mk(0, 8'h20, 0, 0, 0));
        run_idle("burst", 100);
        check_log("burst_order", "DDDDCDD");
        for (int i = 0; i < 6; i++) chk("burst_mem", tbmem[8'h20 + i], i + 1);
        chk("burst_cpu_rdata", bus.rdata, 8'h01);

        // unlocked contention alternates strictly
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            cq.push_back(mk(0, 8'(8'h20 + i), 0, 0, 0));
            dq.push_back(mk(0, 8'(8'h22 + i), 0, 0, 0));
        end
        run_idle("alt", 100);
        check_log("alt_order", "CDCDCDCD");

        // CPU drops req during ACCESS: transfer still completes once
        glog.delete();
        drop_cpu = 1;
        cq.push_back(mk(0, 8'h10, 0, 0, 0));
        run_idle("drop", 20);
        check_log("drop_ack", "C");
        chk("drop_rdata", bus.rdata, 8'hA5);
        glog.delete();
        cq.push_back(mk(0, 8'h10, 0, 0, 0));
        dq.push_back(mk(0, 8'h11, 0, 0, 0));
        run_idle("drop_next", 30);
        check_log("drop_next_order", "DC");

        // reset during the ACCESS cycle of a CPU write aborts it
        tbmem[8'h30] = 8'h5A; refmem[8'h30] = 8'h5A;
        cq.push_back(mk(1, 8'h30, 8'hFF, 0, 0));
        for (int i = 0; i < 10 && m_cd != 2; i++) cycle();
        chk("mid_rst_pre_we", bus.mem_we, 1);
        rst = 0;
        #1;
        chk("mid_rst_we", bus.mem_we, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ack", bus.cpu_ack, 0);
        model_reset();
        reset_drivers();
        glog.delete();
        cq.push_back(mk(1, 8'h31, 8'h77, 0, 0));
        dq.push_back(mk(1, 8'h32, 8'h88, 0, 0));
        cycle(); cycle();
        #1 rst = 1;
        run_idle("post_rst", 40);
        check_log("post_rst_order", "CD");
        chk("mid_rst_mem", tbmem[8'h30], 8'h5A);
        chk("post_rst_mem31", tbmem[8'h31], 8'h77);
        chk("post_rst_mem32", tbmem[8'h32], 8'h88);

        // randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            cq.push_back(mk(1'($urandom), 8'(8'h40 + $urandom_range(0, 15)), 8'($urandom),
                            0, $urandom_range(0, 3)));
            dq.push_back(mk(1'($urandom), 8'(8'h40 + $urandom_range(0, 15)), 8'($urandom),
                            1'($urandom), $urandom_range(0, 3)));
        end
        run_idle("random", 3000);
        for (int i = 8'h40; i < 8'h50; i++) chk("random_mem", tbmem[i], refmem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
